nco_sweep_ctrl: RTL

Sequencer that drives the phase-accumulator NCO through a programmed frequency sweep, e.g. a Doppler search over carrier bins in the GPS signal generator. On a start request it latches a sweep descriptor (start word, signed step, dwell length, step count) and clears the NCO. It then holds each frequency control word for a fixed dwell and steps the word until the sweep completes. It sits between the configuration/register interface and the NCO's `delta_phi`/`ena`/`rst` inputs.

---
 rtl/nco_sweep_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for a phase-accumulator NCO: latches a sweep descriptor, clears the
// NCO, then holds each control word for a dwell and steps it. Define NCO_SWEEP_SAT_EN for saturating steps.
module nco_sweep_ctrl #(
   parameter int FREQ_CTRL_WORD_LEN = 8,
   parameter int DWELL_BITS         = 12,
   parameter int STEP_CNT_BITS      = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic [FREQ_CTRL_WORD_LEN-1:0] start_word,
   input  logic [FREQ_CTRL_WORD_LEN-1:0] step_word,
   input  logic [DWELL_BITS-1:0]         dwell_len,
   input  logic [STEP_CNT_BITS-1:0]      num_steps,
   output logic [FREQ_CTRL_WORD_LEN-1:0] delta_phi,
   output logic                          nco_ena,
   output logic                          nco_rst,
   output logic                          busy,
   output logic                          done,
   output logic [STEP_CNT_BITS-1:0]      step_idx
);

   localparam int W = FREQ_CTRL_WORD_LEN;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DONE
   } state_t;

   state_t                   state, state_nxt;
   logic [W-1:0]             step_word_q, step_word_nxt;
   logic [DWELL_BITS-1:0]    dwell_len_q, dwell_len_nxt;
   logic [STEP_CNT_BITS-1:0] num_steps_q, num_steps_nxt;
   logic [DWELL_BITS-1:0]    dwell_cnt, dwell_cnt_nxt;
   logic [DWELL_BITS-1:0]    dwell_last;
   logic [W-1:0]             delta_phi_nxt;
   logic [STEP_CNT_BITS-1:0] step_idx_nxt;

   // step_word is signed; delta_phi is treated as an unsigned frequency word.
   function automatic logic [W-1:0] step_add(input logic [W-1:0] word, input logic [W-1:0] step);
`ifdef NCO_SWEEP_SAT_EN
      logic signed [W+1:0] sum;
      sum = $signed({2'b00, word}) + $signed({{2{step[W-1]}}, step});
      if (sum[W+1])
         step_add = '0;
      else if (sum[W])
         step_add = '1;
      else
         step_add = sum[W-1:0];
`else
      step_add = word + step;
`endif
   endfunction

   // A dwell length of 0 behaves as 1.
   assign dwell_last = (dwell_len_q == '0) ? '0 : dwell_len_q - 1'b1;

   always_comb begin
      // NOTE: every signal gets a hold default first, so no path leaves one unassigned (no latches).
      state_nxt     = state;
      step_word_nxt = step_word_q;
      dwell_len_nxt = dwell_len_q;
      num_steps_nxt = num_steps_q;
      dwell_cnt_nxt = dwell_cnt;
      delta_phi_nxt = delta_phi;
      step_idx_nxt  = step_idx;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state_nxt     = S_CLEAR;
                  step_word_nxt = step_word;
                  dwell_len_nxt = dwell_len;
                  num_steps_nxt = num_steps;
                  delta_phi_nxt = start_word;
                  step_idx_nxt  = '0;
                  dwell_cnt_nxt = '0;
               end
            end
            S_CLEAR: state_nxt = S_RUN;
            S_RUN: begin
               if (dwell_cnt == dwell_last) begin
                  if (step_idx == num_steps_q) begin
                     state_nxt = S_DONE;
                  end else begin
                     delta_phi_nxt = step_add(delta_phi, step_word_q);
                     step_idx_nxt  = step_idx + 1'b1;
                     dwell_cnt_nxt = '0;
                  end
               end else begin
                  dwell_cnt_nxt = dwell_cnt + 1'b1;
               end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state       <= S_IDLE;
         step_word_q <= '0;
         dwell_len_q <= '0;
         num_steps_q <= '0;
         dwell_cnt   <= '0;
         delta_phi   <= '0;
         step_idx    <= '0;
         nco_ena     <= 1'b0;
         nco_rst     <= 1'b0;
      end else begin
         state       <= state_nxt;
         step_word_q <= step_word_nxt;
         dwell_len_q <= dwell_len_nxt;
         num_steps_q <= num_steps_nxt;
         dwell_cnt   <= dwell_cnt_nxt;
         delta_phi   <= delta_phi_nxt;
         step_idx    <= step_idx_nxt;
         nco_ena     <= (state_nxt == S_RUN);
         nco_rst     <= (state_nxt == S_CLEAR);
      end
   end

   assign busy = (state == S_CLEAR) || (state == S_RUN);
   assign done = (state == S_DONE);

endmodule
